rename_unit: RTL and testbench

//  Parametrised single-issue register-rename stage between decode and dispatch.
//  - Speculative map table plus circular free list (sub-module phys_free_list).
//  - valid/ready handshake on both sides; frees the old physical register on commit.
//  - Optional flush recovery from a retirement map.

---
 rtl/rename_pkg.sv | 18 +
 rtl/rename_unit_if.sv | 39 +++
 rtl/phys_free_list.sv | 89 ++++++++
 rtl/rename_unit.sv | 106 ++++++++++
 tb/tb_rename_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared sizing defaults, index types and the renamed-instruction record for the rename stage.
package rename_pkg;
    localparam int ARCH_REGS_DFLT = 32;
    localparam int PHYS_REGS_DFLT = 64;
    localparam int ARCH_W_DFLT    = $clog2(ARCH_REGS_DFLT);
    localparam int PHYS_W_DFLT    = $clog2(PHYS_REGS_DFLT);

    typedef logic [ARCH_W_DFLT-1:0] arch_idx_t;
    typedef logic [PHYS_W_DFLT-1:0] phys_idx_t;

    typedef struct packed {
        phys_idx_t src1;
        phys_idx_t src2;
        phys_idx_t dest;
        phys_idx_t old;
        logic      dest_valid;
    } rename_out_t;
endpackage

// File: rtl/rename_unit_if.sv
// Decode-side, dispatch-side and commit-side signals of the rename stage.
// master = decode/dispatch/ROB environment, slave = rename_unit.
interface rename_unit_if #(
    parameter int ARCH_W = rename_pkg::ARCH_W_DFLT,
    parameter int PHYS_W = rename_pkg::PHYS_W_DFLT
);
    logic              in_valid;
    logic              in_ready;
    logic [ARCH_W-1:0] in_src1_arch;
    logic [ARCH_W-1:0] in_src2_arch;
    logic [ARCH_W-1:0] in_dest_arch;

    logic              out_valid;
    logic              out_ready;
    logic [PHYS_W-1:0] out_src1_phys;
    logic [PHYS_W-1:0] out_src2_phys;
    logic [PHYS_W-1:0] out_dest_phys;
    logic [PHYS_W-1:0] out_old_phys;
    logic              out_dest_valid;

    logic              commit_valid;
    logic [ARCH_W-1:0] commit_arch;
    logic [PHYS_W-1:0] commit_phys;
    logic [PHYS_W-1:0] commit_old_phys;

    modport master (
        output in_valid, in_src1_arch, in_src2_arch, in_dest_arch, out_ready,
               commit_valid, commit_arch, commit_phys, commit_old_phys,
        input  in_ready, out_valid, out_src1_phys, out_src2_phys, out_dest_phys,
               out_old_phys, out_dest_valid
    );

    modport slave (
        input  in_valid, in_src1_arch, in_src2_arch, in_dest_arch, out_ready,
               commit_valid, commit_arch, commit_phys, commit_old_phys,
        output in_ready, out_valid, out_src1_phys, out_src2_phys, out_dest_phys,
               out_old_phys, out_dest_valid
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical registers; pop/push take effect at the clock edge, head entry is combinational.
// A push when full is dropped and latches err; RENAME_FLUSH_EN adds a retire head that restore rewinds to.
module phys_free_list #(
    parameter int  ARCH_REGS = rename_pkg::ARCH_REGS_DFLT,
    parameter int  PHYS_REGS = rename_pkg::PHYS_REGS_DFLT,
    localparam int PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pop,
    input  logic              push,
    input  logic [PHYS_W-1:0] push_phys,
`ifdef RENAME_FLUSH_EN
    input  logic              retire_adv,
    input  logic              restore,
`endif
    output logic [PHYS_W-1:0] head_phys,
    output logic [PHYS_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam logic [PHYS_W:0] INIT_COUNT = (PHYS_W+1)'(PHYS_REGS - ARCH_REGS);
    localparam logic [PHYS_W:0] CAPACITY   = (PHYS_W+1)'(PHYS_REGS);

    logic [PHYS_W-1:0] slots [PHYS_REGS];
    logic [PHYS_W-1:0] head;
    logic [PHYS_W-1:0] tail;
    logic              push_ok;
    logic              push_drop;
    logic [PHYS_W:0]   count_nxt;

    function automatic logic [PHYS_W-1:0] ptr_inc(input logic [PHYS_W-1:0] p);
        return (p == PHYS_W'(PHYS_REGS - 1)) ? '0 : p + PHYS_W'(1);
    endfunction

    assign full      = (count == CAPACITY);
    assign empty     = (count == '0);
    assign head_phys = slots[head];

    // Phys 0 is the hard-wired zero register and never re-enters the pool.
    assign push_ok   = push && (push_phys != '0) && (!full || pop);
    assign push_drop = push && (push_phys != '0) && full && !pop;

`ifdef RENAME_FLUSH_EN
    logic [PHYS_W-1:0] rhead;
    logic [PHYS_W-1:0] rhead_nxt;
    logic [PHYS_W:0]   spec_cnt;

    assign rhead_nxt = retire_adv ? ptr_inc(rhead) : rhead;
    // Entries between the retire head and the allocation head are speculative and come back on restore.
    assign spec_cnt  = (head >= rhead_nxt) ? (PHYS_W+1)'(head - rhead_nxt)
                                           : CAPACITY - (PHYS_W+1)'(rhead_nxt - head);
`endif

    always_comb begin
        count_nxt = count + (PHYS_W+1)'(push_ok) - (PHYS_W+1)'(pop);
`ifdef RENAME_FLUSH_EN
        if (restore) count_nxt = count + (PHYS_W+1)'(push_ok) + spec_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++)
                slots[i] <= (i < PHYS_REGS - ARCH_REGS) ? PHYS_W'(ARCH_REGS + i) : '0;
            head  <= '0;
            tail  <= PHYS_W'(PHYS_REGS - ARCH_REGS);
            count <= INIT_COUNT;
            err   <= 1'b0;
`ifdef RENAME_FLUSH_EN
            rhead <= '0;
`endif
        end else begin
            count <= count_nxt;
            if (push_ok) begin
                slots[tail] <= push_phys;
                tail        <= ptr_inc(tail);
            end
            if (push_drop) err <= 1'b1;
`ifdef RENAME_FLUSH_EN
            rhead <= rhead_nxt;
            if (restore) head <= rhead_nxt;
            else
`endif
            if (pop) head <= ptr_inc(head);
        end
    end
endmodule

// File: rtl/rename_unit.sv
// Single-issue register rename: map-table lookup plus free-list allocation, registered outputs (latency 1).
// Stalls decode while the output is held or no register is free; RENAME_FLUSH_EN adds flush recovery from a retirement map.
module rename_unit
    import rename_pkg::*;
#(
    parameter int  ARCH_REGS = ARCH_REGS_DFLT,
    parameter int  PHYS_REGS = PHYS_REGS_DFLT,
    localparam int PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic            clk,
    input  logic            reset,
`ifdef RENAME_FLUSH_EN
    input  logic            flush,
`endif
    rename_unit_if.slave    rn,
    output logic [PHYS_W:0] free_count,
    output logic            free_err
);
    logic [PHYS_W-1:0] map [ARCH_REGS];
    logic [PHYS_W-1:0] head_phys;
    logic              fl_empty;
    logic              unused_full;
    logic              flush_blk;
    logic              fire;
    logic              alloc;

`ifdef RENAME_FLUSH_EN
    localparam int ARCH_W = $clog2(ARCH_REGS);
    logic [PHYS_W-1:0] rmap [ARCH_REGS];

    assign flush_blk = flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) rmap[i] <= PHYS_W'(i);
        end else if (rn.commit_valid && rn.commit_arch != '0) begin
            rmap[rn.commit_arch] <= rn.commit_phys;
        end
    end
`else
    logic unused_commit;

    assign flush_blk     = 1'b0;
    assign unused_commit = ^{rn.commit_arch, rn.commit_phys};
`endif

    // A free arriving with the list empty is not forwarded: allocation waits for the registered count.
    assign rn.in_ready = (!rn.out_valid || rn.out_ready)
                       && (!fl_empty || rn.in_dest_arch == '0)
                       && !flush_blk;
    assign fire  = rn.in_valid && rn.in_ready;
    assign alloc = fire && (rn.in_dest_arch != '0);

    phys_free_list #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_free_list (
        .clk        (clk),
        .reset      (reset),
        .pop        (alloc),
        .push       (rn.commit_valid),
        .push_phys  (rn.commit_old_phys),
`ifdef RENAME_FLUSH_EN
        .retire_adv (rn.commit_valid),
        .restore    (flush),
`endif
        .head_phys  (head_phys),
        .count      (free_count),
        .full       (unused_full),
        .empty      (fl_empty),
        .err        (free_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rn.out_valid      <= 1'b0;
            rn.out_src1_phys  <= '0;
            rn.out_src2_phys  <= '0;
            rn.out_dest_phys  <= '0;
            rn.out_old_phys   <= '0;
            rn.out_dest_valid <= 1'b0;
            for (int i = 0; i < ARCH_REGS; i++) map[i] <= PHYS_W'(i);
        end
`ifdef RENAME_FLUSH_EN
        else if (flush) begin
            rn.out_valid <= 1'b0;
            // A commit in the flush cycle is folded in before the copy.
            for (int i = 1; i < ARCH_REGS; i++)
                map[i] <= (rn.commit_valid && rn.commit_arch == ARCH_W'(i)) ? rn.commit_phys : rmap[i];
        end
`endif
        else begin
            if (fire) begin
                rn.out_valid      <= 1'b1;
                rn.out_src1_phys  <= map[rn.in_src1_arch];
                rn.out_src2_phys  <= map[rn.in_src2_arch];
                rn.out_dest_phys  <= alloc ? head_phys : '0;
                rn.out_old_phys   <= alloc ? map[rn.in_dest_arch] : '0;
                rn.out_dest_valid <= alloc;
                if (alloc) map[rn.in_dest_arch] <= head_phys;
            end else if (rn.out_ready) begin
                rn.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: vector table, directed corner sequences, then random traffic against a queue-based model.
// Flush scenarios are compiled in when RENAME_FLUSH_EN is defined.
module tb_rename_unit;
    import rename_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [PHYS_W_DFLT:0] free_count;
    logic                 free_err;
`ifdef RENAME_FLUSH_EN
    logic                 flush;
`endif

    rename_unit_if rif ();

    rename_unit dut (
        .clk        (clk),
        .reset      (reset),
`ifdef RENAME_FLUSH_EN
        .flush      (flush),
`endif
        .rn         (rif),
        .free_count (free_count),
        .free_err   (free_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit iv; int s1; int s2; int d; bit ordy; bit cv; int cold;
        bit e_rdy; bit e_ov; int e_s1; int e_s2; int e_d; int e_o; bit e_dv; int e_cnt;
    } vec_t;

    typedef struct { int arch; int phys; int old; } rob_t;

    // Reference model: map as an array, free list and speculative allocations as queues.
    int          m_map  [ARCH_REGS_DFLT];
    int          m_rmap [ARCH_REGS_DFLT];
    int          m_fl   [$];
    int          m_spec [$];
    bit          m_err;
    bit          m_ov;
    int          m_arch_d;
    rename_out_t m_out;
    rob_t        rob [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input int s1, input int s2, input int d,
                         input bit ordy, input bit cv, input int cold);
        rif.in_valid        = iv;
        rif.in_src1_arch    = ARCH_W_DFLT'(s1);
        rif.in_src2_arch    = ARCH_W_DFLT'(s2);
        rif.in_dest_arch    = ARCH_W_DFLT'(d);
        rif.out_ready       = ordy;
        rif.commit_valid    = cv;
        rif.commit_arch     = '0;
        rif.commit_phys     = '0;
        rif.commit_old_phys = PHYS_W_DFLT'(cold);
`ifdef RENAME_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string name, input bit exp);
        @(negedge clk);
        chk(name, rif.in_ready, exp);
    endtask

    task automatic chk_out(input string name, input bit ov, input int s1, input int s2,
                           input int d, input int o, input bit dv);
        chk({name, "_vld"}, rif.out_valid, ov);
        chk({name, "_src1"}, rif.out_src1_phys, s1);
        chk({name, "_src2"}, rif.out_src2_phys, s2);
        chk({name, "_dest"}, rif.out_dest_phys, d);
        chk({name, "_old"}, rif.out_old_phys, o);
        chk({name, "_dvld"}, rif.out_dest_valid, dv);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
        chk_out(name, 0, 0, 0, 0, 0, 0);
        chk({name, "_cnt"}, free_count, PHYS_REGS_DFLT - ARCH_REGS_DFLT);
        chk({name, "_err"}, free_err, 0);
        chk({name, "_rdy"}, rif.in_ready, 1);
        reset = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS_DFLT; i++) begin
            m_map[i]  = i;
            m_rmap[i] = i;
        end
        m_fl.delete();
        for (int p = ARCH_REGS_DFLT; p < PHYS_REGS_DFLT; p++) m_fl.push_back(p);
        m_spec.delete();
        rob.delete();
        m_err = 0;
        m_ov  = 0;
        m_out = '0;
    endtask

    function automatic bit model_ready(input int d, input bit ordy, input bit fl);
        return (!m_ov || ordy) && (m_fl.size() != 0 || d == 0) && !fl;
    endfunction

    task automatic model_free(input int cold, input int size0, input bit popped);
        if (cold != 0) begin
            if (size0 == PHYS_REGS_DFLT && !popped) m_err = 1;
            else m_fl.push_back(cold);
        end
    endtask

    task automatic model_commit(input bit cv, input int carch, input int cphys, input int cold,
                                input int size0, input bit popped);
        if (cv) begin
            if (carch != 0) m_rmap[carch] = cphys;
            if (m_spec.size() != 0) void'(m_spec.pop_front());
            model_free(cold, size0, popped);
        end
    endtask

    task automatic model_step(input bit iv, input int s1, input int s2, input int d, input bit ordy,
                              input bit cv, input int carch, input int cphys, input int cold, input bit fl);
        int  size0;
        bit  fire;
        int  ph;
        size0 = m_fl.size();
        if (fl) begin
            model_commit(cv, carch, cphys, cold, size0, 0);
            for (int j = m_spec.size() - 1; j >= 0; j--) m_fl.push_front(m_spec[j]);
            m_spec.delete();
            for (int i = 0; i < ARCH_REGS_DFLT; i++) m_map[i] = m_rmap[i];
            m_ov = 0;
        end else begin
            fire = iv && model_ready(d, ordy, fl);
            if (fire) begin
                m_ov          = 1;
                m_arch_d      = d;
                m_out.src1    = phys_idx_t'(m_map[s1]);
                m_out.src2    = phys_idx_t'(m_map[s2]);
                m_out.dest    = '0;
                m_out.old     = '0;
                m_out.dest_valid = (d != 0);
                if (d != 0) begin
                    ph = m_fl.pop_front();
                    m_spec.push_back(ph);
                    m_out.dest = phys_idx_t'(ph);
                    m_out.old  = phys_idx_t'(m_map[d]);
                    m_map[d]   = ph;
                end
            end else if (ordy) begin
                m_ov = 0;
            end
            model_commit(cv, carch, cphys, cold, size0, fire && d != 0);
        end
    endtask

    vec_t tbl [8];
    bit   iv, ordy, cv, rs, fl;
    int   s1, s2, d, carch, cphys, cold;
    rob_t r;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);

        // iv s1 s2 d ordy cv cold | rdy ov s1 s2 dest old dv cnt
        tbl[0] = '{1, 5, 0, 5, 1, 0, 0,  1, 1, 5,  0, 32, 5,  1, 31};
        tbl[1] = '{1, 5, 7, 0, 1, 0, 0,  1, 1, 32, 7, 0,  0,  0, 31};
        tbl[2] = '{1, 5, 5, 5, 1, 0, 0,  1, 1, 32, 32, 33, 32, 1, 30};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 5,  1, 0, 0,  0, 0,  0,  0, 31};
        tbl[4] = '{1, 0, 3, 3, 0, 0, 0,  1, 1, 0,  3, 34, 3,  1, 30};
        tbl[5] = '{1, 1, 2, 1, 0, 0, 0,  0, 1, 0,  3, 34, 3,  1, 30};
        tbl[6] = '{1, 1, 2, 1, 1, 0, 0,  1, 1, 1,  2, 35, 1,  1, 29};
        tbl[7] = '{0, 0, 0, 0, 1, 1, 0,  1, 0, 0,  0, 0,  0,  0, 29};

        do_reset("rst0");
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].iv, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].ordy, tbl[i].cv, tbl[i].cold);
            chk_rdy($sformatf("tbl%0d_rdy", i), tbl[i].e_rdy);
            tick();
            chk($sformatf("tbl%0d_vld", i), rif.out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov)
                chk_out($sformatf("tbl%0d", i), 1, tbl[i].e_s1, tbl[i].e_s2, tbl[i].e_d, tbl[i].e_o, tbl[i].e_dv);
            chk($sformatf("tbl%0d_cnt", i), free_count, tbl[i].e_cnt);
        end

        // Exhaust the free list, then recover through a commit.
        do_reset("rst_exh");
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, (i % 31) + 1, 1, 0, 0);
            tick();
        end
        chk_out("exh_last", 1, 0, 0, 63, 32, 1);
        chk("exh_cnt", free_count, 0);
        drive(1, 0, 0, 7, 1, 0, 0);
        chk_rdy("exh_rdy", 0);
        tick();
        chk("exh_idle_vld", rif.out_valid, 0);
        drive(1, 7, 0, 0, 1, 0, 0);
        chk_rdy("nodest_rdy", 1);
        tick();
        chk_out("nodest", 1, 38, 0, 0, 0, 0);
        chk("nodest_cnt", free_count, 0);
        drive(0, 0, 0, 0, 1, 1, 5);
        tick();
        chk("free5_cnt", free_count, 1);
        drive(1, 0, 0, 7, 1, 0, 0);
        chk_rdy("free5_rdy", 1);
        tick();
        chk_out("realloc5", 1, 0, 0, 5, 38, 1);
        chk("realloc5_cnt", free_count, 0);

        // Same-cycle alloc and free at count 1, then no bypass at count 0.
        drive(0, 0, 0, 0, 1, 1, 9);
        tick();
        drive(1, 0, 0, 2, 1, 1, 10);
        chk_rdy("same_rdy", 1);
        tick();
        chk_out("same", 1, 0, 0, 9, 33, 1);
        chk("same_cnt", free_count, 1);
        drive(1, 0, 0, 2, 1, 0, 0);
        tick();
        chk_out("drain", 1, 0, 0, 10, 9, 1);
        drive(1, 0, 0, 3, 1, 1, 11);
        chk_rdy("nobyp_rdy", 0);
        tick();
        chk("nobyp_vld", rif.out_valid, 0);
        chk("nobyp_cnt", free_count, 1);

        // Output stall for three cycles, then release.
        do_reset("rst_stall");
        drive(1, 1, 2, 4, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4, 0, 6, 0, 0, 0);
            chk_rdy($sformatf("stall%0d_rdy", k), 0);
            tick();
            chk_out($sformatf("stall%0d", k), 1, 1, 2, 32, 4, 1);
        end
        drive(1, 4, 0, 6, 1, 0, 0);
        chk_rdy("release_rdy", 1);
        tick();
        chk_out("release", 1, 32, 0, 33, 6, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("release_vld", rif.out_valid, 0);
        chk("release_cnt", free_count, 30);

        // Overfill the free list.
        do_reset("rst_full");
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 1, 1, 40);
            tick();
        end
        chk("full_cnt", free_count, 64);
        chk("full_err0", free_err, 0);
        drive(0, 0, 0, 0, 1, 1, 41);
        tick();
        chk("full_err1", free_err, 1);
        chk("full_cnt2", free_count, 64);
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("full_sticky", free_err, 1);

`ifdef RENAME_FLUSH_EN
        do_reset("rst_flush");
        drive(1, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 0, 0, 4, 1, 0, 0);
        tick();
        // Retire r3 without freeing its previous mapping so the count reflects only the recovery.
        drive(0, 0, 0, 0, 1, 1, 0);
        rif.commit_arch = ARCH_W_DFLT'(3);
        rif.commit_phys = PHYS_W_DFLT'(32);
        tick();
        drive(1, 0, 0, 0, 1, 0, 0);
        flush = 1'b1;
        chk_rdy("flush_rdy", 0);
        tick();
        chk("flush_vld", rif.out_valid, 0);
        chk("flush_cnt", free_count, 31);
        drive(1, 3, 4, 5, 1, 0, 0);
        tick();
        chk_out("post_flush", 1, 32, 4, 33, 5, 1);
`endif

        // Random traffic against the model; commits retire dispatched allocations in order.
        do_reset("rst_rand");
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iv   = ($urandom_range(0, 3) != 0);
            s1   = $urandom_range(0, 31);
            s2   = $urandom_range(0, 31);
            d    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            ordy = ($urandom_range(0, 9) < 7);
            cv = 0; carch = 0; cphys = 0; cold = 0;
            if (rob.size() != 0 && $urandom_range(0, 2) == 0) begin
                r = rob.pop_front();
                cv = 1; carch = r.arch; cphys = r.phys; cold = r.old;
            end
            rs = ($urandom_range(0, 499) == 0);
            fl = 0;
            drive(iv, s1, s2, d, ordy, cv, cold);
            rif.commit_arch = ARCH_W_DFLT'(carch);
            rif.commit_phys = PHYS_W_DFLT'(cphys);
`ifdef RENAME_FLUSH_EN
            fl    = ($urandom_range(0, 79) == 0);
            flush = fl;
`endif
            reset = rs;
            @(negedge clk);
            if (!rs) chk("rand_rdy", rif.in_ready, model_ready(d, ordy, fl));
            chk("rand_vld", rif.out_valid, m_ov);
            if (m_ov) chk_out("rand", 1, m_out.src1, m_out.src2, m_out.dest, m_out.old, m_out.dest_valid);
            chk("rand_cnt", free_count, m_fl.size());
            chk("rand_err", free_err, m_err);
            if (!rs && !fl && m_ov && ordy && m_out.dest_valid)
                rob.push_back('{m_arch_d, int'(m_out.dest), int'(m_out.old)});
            if (rs) model_reset();
            else model_step(iv, s1, s2, d, ordy, cv, carch, cphys, cold, fl);
            if (fl) rob.delete();
            tick();
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
